// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage pipelined core.
//   Forwards operands from MEM/WB, evaluates the ALU, resolves branches and
//   jumps, runs a 32-iteration restoring divider (stalling the front end),
//   and drives the registered EX/MEM bundle. The EX/MEM contents are saved
//   on interrupt entry and restored on interrupt return.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   INT_detected, INT_restore  interrupt entry / return strobes
//   EX_*                       ID/EX data, register indices and control
//   MEM_fwd_*, WB_*            forwarding sources (MEM wins over WB)
//   EX_stall                   hold PC and IF/ID, flush ID/EX
//   EX_Flush_branch, EX_branch_target  combinational redirect
//   MEM_*                      registered EX/MEM bundle
module ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        INT_detected,
  input  logic        INT_restore,
  input  logic [31:0] EX_PC,
  input  logic [31:0] EX_RD1,
  input  logic [31:0] EX_RD2,
  input  logic [31:0] EX_immout,
  input  logic [4:0]  EX_rs1,
  input  logic [4:0]  EX_rs2,
  input  logic [4:0]  EX_rd,
  input  logic [2:0]  EX_dm_ctrl,
  input  logic [4:0]  EX_ALUOp,
  input  logic [1:0]  EX_WDSel,
  input  logic [2:0]  EX_NPCOp,
  input  logic        EX_RegWrite,
  input  logic        EX_mem_w,
  input  logic        EX_mem_read,
  input  logic        EX_ALUSrc,
  input  logic        MEM_fwd_RegWrite,
  input  logic [4:0]  MEM_fwd_rd,
  input  logic [31:0] MEM_fwd_data,
  input  logic        WB_RegWrite,
  input  logic [4:0]  WB_rd,
  input  logic [31:0] WB_WD,
  output logic        EX_stall,
  output logic        EX_Flush_branch,
  output logic [31:0] EX_branch_target,
  output logic [31:0] MEM_PC,
  output logic [31:0] MEM_aluout,
  output logic [31:0] MEM_wdata,
  output logic [4:0]  MEM_rd,
  output logic [2:0]  MEM_dm_ctrl,
  output logic [1:0]  MEM_WDSel,
  output logic        MEM_RegWrite,
  output logic        MEM_mem_w,
  output logic        MEM_mem_read
);

  localparam int unsigned DIV_CYCLES = 32;

  typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] aluout;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [2:0]  dm_ctrl;
    logic [1:0]  wdsel;
    logic        regwrite;
    logic        mem_w;
    logic        mem_read;
  } exmem_t;

  // EX/MEM register, interrupt backup, divider state
  exmem_t      mem_q, bkp_q;
  div_state_e  div_state_q;
  logic [4:0]  div_cnt_q;
  logic [31:0] div_quo_q, div_rem_q, div_dvs_q;
  logic        div_neg_q_q, div_neg_r_q, div_rem_sel_q;
  logic [31:0] div_pc_q;
  logic [4:0]  div_rd_q;
  logic        div_regwrite_q;
  logic [1:0]  div_wdsel_q;

  // Combinational datapath
  logic [31:0] fwd_a, fwd_b, alu_b, alu_res;
  logic [4:0]  shamt;
  logic        br_cmp, taken, jump, is_div;
  logic        acc_signed, acc_sa, acc_sb;
  logic [31:0] acc_mag_a, acc_mag_b;
  logic [32:0] div_shift, div_diff;
  logic        div_borrow;
  logic [31:0] div_quo_d, div_rem_d, div_q_res, div_r_res, div_res;
  exmem_t      mem_norm, mem_div;

  always_comb begin
    fwd_a = EX_RD1;
    if (MEM_fwd_RegWrite && (MEM_fwd_rd != '0) && (MEM_fwd_rd == EX_rs1))
      fwd_a = MEM_fwd_data;
    else if (WB_RegWrite && (WB_rd != '0) && (WB_rd == EX_rs1))
      fwd_a = WB_WD;

    fwd_b = EX_RD2;
    if (MEM_fwd_RegWrite && (MEM_fwd_rd != '0) && (MEM_fwd_rd == EX_rs2))
      fwd_b = MEM_fwd_data;
    else if (WB_RegWrite && (WB_rd != '0) && (WB_rd == EX_rs2))
      fwd_b = WB_WD;
  end

  assign alu_b  = EX_ALUSrc ? EX_immout : fwd_b;
  assign shamt  = alu_b[4:0];
  assign is_div = (EX_ALUOp[4:2] == 3'b011);

  // Branch compares use the forwarded register operand, never the immediate
  always_comb begin
    br_cmp = 1'b0;
    case (EX_ALUOp)
      5'h10:   br_cmp = (fwd_a == fwd_b);
      5'h11:   br_cmp = (fwd_a != fwd_b);
      5'h12:   br_cmp = ($signed(fwd_a) <  $signed(fwd_b));
      5'h13:   br_cmp = ($signed(fwd_a) >= $signed(fwd_b));
      5'h14:   br_cmp = (fwd_a <  fwd_b);
      5'h15:   br_cmp = (fwd_a >= fwd_b);
      default: br_cmp = 1'b0;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (EX_ALUOp)
      5'h00:   alu_res = fwd_a + alu_b;
      5'h01:   alu_res = fwd_a - alu_b;
      5'h02:   alu_res = fwd_a << shamt;
      5'h03:   alu_res = {31'b0, ($signed(fwd_a) < $signed(alu_b))};
      5'h04:   alu_res = {31'b0, (fwd_a < alu_b)};
      5'h05:   alu_res = fwd_a ^ alu_b;
      5'h06:   alu_res = fwd_a >> shamt;
      5'h07:   alu_res = 32'($signed(fwd_a) >>> shamt);
      5'h08:   alu_res = fwd_a | alu_b;
      5'h09:   alu_res = fwd_a & alu_b;
      5'h0A:   alu_res = alu_b;
      5'h0B:   alu_res = EX_PC + alu_b;
      5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h15:
               alu_res = {31'b0, br_cmp};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    taken            = 1'b0;
    jump             = 1'b0;
    EX_branch_target = EX_PC + EX_immout;
    case (EX_NPCOp)
      3'b001:  taken = br_cmp;
      3'b010:  jump  = 1'b1;
      3'b100: begin
        jump             = 1'b1;
        EX_branch_target = (fwd_a + EX_immout) & ~32'h1;
      end
      default: ;
    endcase
  end

  assign EX_Flush_branch = (taken | jump) & ~INT_detected & (div_state_q == DIV_IDLE);
  assign EX_stall        = ((div_state_q == DIV_IDLE) & is_div) | (div_state_q == DIV_RUN);

  // Divider operand preparation at accept
  assign acc_signed = ~EX_ALUOp[0];
  assign acc_sa     = acc_signed & fwd_a[31];
  assign acc_sb     = acc_signed & alu_b[31];
  assign acc_mag_a  = acc_sa ? (32'd0 - fwd_a) : fwd_a;
  assign acc_mag_b  = acc_sb ? (32'd0 - alu_b) : alu_b;

  // Restoring step: shifted partial remainder minus divisor; the top bit of
  // the 33-bit difference is the borrow because rem < divisor is invariant
  // (and for a zero divisor the partial remainder never reaches bit 32).
  always_comb begin
    div_shift  = {div_rem_q, div_quo_q[31]};
    div_diff   = div_shift - {1'b0, div_dvs_q};
    div_borrow = div_diff[32];
    div_rem_d  = div_borrow ? div_shift[31:0] : div_diff[31:0];
    div_quo_d  = {div_quo_q[30:0], ~div_borrow};
  end

  // Zero divisor falls out of the iteration (all-ones quotient, remainder =
  // dividend magnitude); quotient negation is suppressed for it at accept.
  assign div_q_res = div_neg_q_q ? (32'd0 - div_quo_q) : div_quo_q;
  assign div_r_res = div_neg_r_q ? (32'd0 - div_rem_q) : div_rem_q;
  assign div_res   = div_rem_sel_q ? div_r_res : div_q_res;

  always_comb begin
    mem_norm.pc       = EX_PC;
    mem_norm.aluout   = (EX_WDSel == 2'b10) ? (EX_PC + 32'd4) : alu_res;
    mem_norm.wdata    = fwd_b;
    mem_norm.rd       = EX_rd;
    mem_norm.dm_ctrl  = EX_dm_ctrl;
    mem_norm.wdsel    = EX_WDSel;
    mem_norm.regwrite = EX_RegWrite;
    mem_norm.mem_w    = EX_mem_w;
    mem_norm.mem_read = EX_mem_read;

    mem_div           = '0;
    mem_div.pc        = div_pc_q;
    mem_div.aluout    = (div_wdsel_q == 2'b10) ? (div_pc_q + 32'd4) : div_res;
    mem_div.rd        = div_rd_q;
    mem_div.wdsel     = div_wdsel_q;
    mem_div.regwrite  = div_regwrite_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q          <= '0;
      bkp_q          <= '0;
      div_state_q    <= DIV_IDLE;
      div_cnt_q      <= '0;
      div_quo_q      <= '0;
      div_rem_q      <= '0;
      div_dvs_q      <= '0;
      div_neg_q_q    <= 1'b0;
      div_neg_r_q    <= 1'b0;
      div_rem_sel_q  <= 1'b0;
      div_pc_q       <= '0;
      div_rd_q       <= '0;
      div_regwrite_q <= 1'b0;
      div_wdsel_q    <= '0;
    end else if (INT_detected) begin
      bkp_q <= mem_q;
      mem_q <= '0;
    end else if (INT_restore) begin
      mem_q <= bkp_q;
    end else begin
      case (div_state_q)
        DIV_IDLE: begin
          if (is_div) begin
            div_quo_q      <= acc_mag_a;
            div_rem_q      <= '0;
            div_dvs_q      <= acc_mag_b;
            div_neg_q_q    <= (acc_sa ^ acc_sb) & (alu_b != '0);
            div_neg_r_q    <= acc_sa;
            div_rem_sel_q  <= EX_ALUOp[1];
            div_pc_q       <= EX_PC;
            div_rd_q       <= EX_rd;
            div_regwrite_q <= EX_RegWrite;
            div_wdsel_q    <= EX_WDSel;
            div_cnt_q      <= '0;
            div_state_q    <= DIV_RUN;
            mem_q          <= '0;
          end else begin
            mem_q <= mem_norm;
          end
        end
        DIV_RUN: begin
          div_quo_q <= div_quo_d;
          div_rem_q <= div_rem_d;
          mem_q     <= '0;
          if (div_cnt_q == 5'(DIV_CYCLES - 1)) begin
            div_cnt_q   <= '0;
            div_state_q <= DIV_DONE;
          end else begin
            div_cnt_q <= div_cnt_q + 5'd1;
          end
        end
        DIV_DONE: begin
          mem_q       <= mem_div;
          div_state_q <= DIV_IDLE;
        end
        default: div_state_q <= DIV_IDLE;
      endcase
    end
  end

  assign MEM_PC       = mem_q.pc;
  assign MEM_aluout   = mem_q.aluout;
  assign MEM_wdata    = mem_q.wdata;
  assign MEM_rd       = mem_q.rd;
  assign MEM_dm_ctrl  = mem_q.dm_ctrl;
  assign MEM_WDSel    = mem_q.wdsel;
  assign MEM_RegWrite = mem_q.regwrite;
  assign MEM_mem_w    = mem_q.mem_w;
  assign MEM_mem_read = mem_q.mem_read;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: scoreboard bench for ex_stage. Stimulus pushes expected
// values tagged with the cycle they must be visible in; a negedge monitor
// pops and compares them.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        INT_detected, INT_restore;
  logic [31:0] EX_PC, EX_RD1, EX_RD2, EX_immout;
  logic [4:0]  EX_rs1, EX_rs2, EX_rd;
  logic [2:0]  EX_dm_ctrl;
  logic [4:0]  EX_ALUOp;
  logic [1:0]  EX_WDSel;
  logic [2:0]  EX_NPCOp;
  logic        EX_RegWrite, EX_mem_w, EX_mem_read, EX_ALUSrc;
  logic        MEM_fwd_RegWrite;
  logic [4:0]  MEM_fwd_rd;
  logic [31:0] MEM_fwd_data;
  logic        WB_RegWrite;
  logic [4:0]  WB_rd;
  logic [31:0] WB_WD;
  logic        EX_stall, EX_Flush_branch;
  logic [31:0] EX_branch_target, MEM_PC, MEM_aluout, MEM_wdata;
  logic [4:0]  MEM_rd;
  logic [2:0]  MEM_dm_ctrl;
  logic [1:0]  MEM_WDSel;
  logic        MEM_RegWrite, MEM_mem_w, MEM_mem_read;

  ex_stage dut (
    .clk(clk), .reset(reset),
    .INT_detected(INT_detected), .INT_restore(INT_restore),
    .EX_PC(EX_PC), .EX_RD1(EX_RD1), .EX_RD2(EX_RD2), .EX_immout(EX_immout),
    .EX_rs1(EX_rs1), .EX_rs2(EX_rs2), .EX_rd(EX_rd),
    .EX_dm_ctrl(EX_dm_ctrl), .EX_ALUOp(EX_ALUOp), .EX_WDSel(EX_WDSel),
    .EX_NPCOp(EX_NPCOp), .EX_RegWrite(EX_RegWrite), .EX_mem_w(EX_mem_w),
    .EX_mem_read(EX_mem_read), .EX_ALUSrc(EX_ALUSrc),
    .MEM_fwd_RegWrite(MEM_fwd_RegWrite), .MEM_fwd_rd(MEM_fwd_rd),
    .MEM_fwd_data(MEM_fwd_data),
    .WB_RegWrite(WB_RegWrite), .WB_rd(WB_rd), .WB_WD(WB_WD),
    .EX_stall(EX_stall), .EX_Flush_branch(EX_Flush_branch),
    .EX_branch_target(EX_branch_target),
    .MEM_PC(MEM_PC), .MEM_aluout(MEM_aluout), .MEM_wdata(MEM_wdata),
    .MEM_rd(MEM_rd), .MEM_dm_ctrl(MEM_dm_ctrl), .MEM_WDSel(MEM_WDSel),
    .MEM_RegWrite(MEM_RegWrite), .MEM_mem_w(MEM_mem_w),
    .MEM_mem_read(MEM_mem_read)
  );

  always #5 clk = ~clk;

  typedef enum logic [2:0] {K_ALU, K_RD, K_RW, K_STALL, K_FLUSH, K_TGT, K_PC, K_WDATA} chk_e;
  typedef struct {
    int unsigned due;
    chk_e        kind;
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned n_tests = 0;
  int unsigned n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] probe(input chk_e k);
    case (k)
      K_ALU:   return MEM_aluout;
      K_RD:    return {27'b0, MEM_rd};
      K_RW:    return {31'b0, MEM_RegWrite};
      K_STALL: return {31'b0, EX_stall};
      K_FLUSH: return {31'b0, EX_Flush_branch};
      K_TGT:   return EX_branch_target;
      K_PC:    return MEM_PC;
      default: return MEM_wdata;
    endcase
  endfunction

  // Monitor: compare every expectation due in the current cycle
  exp_t        mon_e;
  logic [31:0] mon_act;
  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].due <= cyc) begin
      mon_e   = sb.pop_front();
      mon_act = probe(mon_e.kind);
      n_tests++;
      if (mon_e.due != cyc || mon_act !== mon_e.exp) begin
        n_fail++;
        $display("FAIL %s cyc=%0d due=%0d got=%h exp=%h",
                 mon_e.name, cyc, mon_e.due, mon_act, mon_e.exp);
      end
    end
  end

  task automatic expect_at(input int unsigned due, input chk_e k,
                           input string n, input logic [31:0] v);
    exp_t e;
    e.due = due; e.kind = k; e.name = n; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    EX_PC = '0; EX_RD1 = '0; EX_RD2 = '0; EX_immout = '0;
    EX_rs1 = '0; EX_rs2 = '0; EX_rd = '0; EX_dm_ctrl = '0;
    EX_ALUOp = '0; EX_WDSel = '0; EX_NPCOp = '0;
    EX_RegWrite = 1'b0; EX_mem_w = 1'b0; EX_mem_read = 1'b0; EX_ALUSrc = 1'b0;
    MEM_fwd_RegWrite = 1'b0; MEM_fwd_rd = '0; MEM_fwd_data = '0;
    WB_RegWrite = 1'b0; WB_rd = '0; WB_WD = '0;
  endtask

  // Divide with full stall-window and latency checks; leaves cyc = start+34
  task automatic run_div(input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input string name);
    int unsigned c;
    c = cyc;
    clear_ex();
    EX_ALUOp = op; EX_RD1 = a; EX_RD2 = b; EX_rd = 5'd3; EX_RegWrite = 1'b1;
    for (int unsigned i = 0; i < 33; i++) expect_at(c + i, K_STALL, {name, "_stall"}, 32'd1);
    expect_at(c + 33, K_STALL, {name, "_stall_done"}, 32'd0);
    expect_at(c + 33, K_ALU, {name, "_bubble"}, 32'd0);
    expect_at(c + 34, K_ALU, name, exp);
    expect_at(c + 34, K_RD, {name, "_rd"}, 32'd3);
    step();
    clear_ex();
    repeat (33) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    int unsigned c;
    reset = 1'b1; INT_detected = 1'b0; INT_restore = 1'b0;
    clear_ex();
    step(); step();
    reset = 1'b0;

    // Reset state
    expect_at(cyc, K_ALU,   "rst_aluout", 32'd0);
    expect_at(cyc, K_RD,    "rst_rd",     32'd0);
    expect_at(cyc, K_RW,    "rst_rw",     32'd0);
    expect_at(cyc, K_PC,    "rst_pc",     32'd0);
    expect_at(cyc, K_STALL, "rst_stall",  32'd0);
    expect_at(cyc, K_FLUSH, "rst_flush",  32'd0);
    step();

    // Forwarding: MEM beats WB
    clear_ex();
    EX_ALUOp = 5'h00; EX_rs1 = 5'd5; EX_RD1 = 32'd1; EX_RD2 = 32'd3;
    EX_rd = 5'd7; EX_RegWrite = 1'b1; EX_PC = 32'h10;
    MEM_fwd_RegWrite = 1'b1; MEM_fwd_rd = 5'd5; MEM_fwd_data = 32'd7;
    WB_RegWrite = 1'b1; WB_rd = 5'd5; WB_WD = 32'd9;
    expect_at(cyc + 1, K_ALU,   "fwd_mem",    32'd10);
    expect_at(cyc + 1, K_RD,    "fwd_mem_rd", 32'd7);
    expect_at(cyc + 1, K_RW,    "fwd_mem_rw", 32'd1);
    expect_at(cyc + 1, K_PC,    "fwd_mem_pc", 32'h10);
    expect_at(cyc + 1, K_WDATA, "fwd_wdata",  32'd3);
    step();
    // rd=0 on both sources disables forwarding
    MEM_fwd_rd = 5'd0; WB_rd = 5'd0; EX_rs1 = 5'd0;
    expect_at(cyc + 1, K_ALU, "fwd_rd0", 32'd4);
    step();
    // WB only
    EX_rs1 = 5'd5; MEM_fwd_rd = 5'd5; MEM_fwd_RegWrite = 1'b0; WB_rd = 5'd5;
    expect_at(cyc + 1, K_ALU, "fwd_wb", 32'd12);
    step();
    // Forward B into store data, SUB with operand B forwarded from MEM
    clear_ex();
    EX_ALUOp = 5'h01; EX_RD1 = 32'd100; EX_rs2 = 5'd4; EX_RD2 = 32'd1;
    MEM_fwd_RegWrite = 1'b1; MEM_fwd_rd = 5'd4; MEM_fwd_data = 32'd30;
    expect_at(cyc + 1, K_ALU,   "sub_fwdb",   32'd70);
    expect_at(cyc + 1, K_WDATA, "wdata_fwdb", 32'd30);
    step();
    // SRA with immediate shift amount
    clear_ex();
    EX_ALUOp = 5'h07; EX_RD1 = 32'h8000_0000; EX_ALUSrc = 1'b1; EX_immout = 32'd4;
    expect_at(cyc + 1, K_ALU, "sra", 32'hF800_0000);
    step();
    // SLT signed vs SLTU
    clear_ex();
    EX_ALUOp = 5'h03; EX_RD1 = 32'hFFFF_FFFF; EX_RD2 = 32'd1;
    expect_at(cyc + 1, K_ALU, "slt", 32'd1);
    step();
    EX_ALUOp = 5'h04;
    expect_at(cyc + 1, K_ALU, "sltu", 32'd0);
    step();
    // AUIPC and undefined op
    clear_ex();
    EX_ALUOp = 5'h0B; EX_PC = 32'h1000; EX_ALUSrc = 1'b1; EX_immout = 32'h2000;
    expect_at(cyc + 1, K_ALU, "auipc", 32'h3000);
    step();
    EX_ALUOp = 5'h1F; EX_RD1 = 32'h1234;
    expect_at(cyc + 1, K_ALU, "undef_op", 32'd0);
    step();

    // BLT taken (signed), BLTU not taken
    clear_ex();
    EX_ALUOp = 5'h12; EX_NPCOp = 3'b001; EX_RD1 = 32'hFFFF_FFFF; EX_RD2 = 32'd1;
    EX_PC = 32'h100; EX_immout = 32'h20;
    expect_at(cyc, K_FLUSH, "blt_flush",  32'd1);
    expect_at(cyc, K_TGT,   "blt_target", 32'h120);
    step();
    EX_ALUOp = 5'h14;
    expect_at(cyc, K_FLUSH, "bltu_flush", 32'd0);
    step();

    // JAL and JALR
    clear_ex();
    EX_NPCOp = 3'b010; EX_PC = 32'h80; EX_immout = 32'h10;
    expect_at(cyc, K_FLUSH, "jal_flush",  32'd1);
    expect_at(cyc, K_TGT,   "jal_target", 32'h90);
    step();
    clear_ex();
    EX_NPCOp = 3'b100; EX_ALUOp = 5'h00; EX_RD1 = 32'h203; EX_immout = 32'h0;
    EX_ALUSrc = 1'b1; EX_WDSel = 2'b10; EX_PC = 32'h40; EX_rd = 5'd1; EX_RegWrite = 1'b1;
    expect_at(cyc,     K_FLUSH, "jalr_flush",  32'd1);
    expect_at(cyc,     K_TGT,   "jalr_target", 32'h202);
    expect_at(cyc + 1, K_ALU,   "jalr_link",   32'h44);
    step();
    clear_ex();
    step();

    // Divides
    run_div(5'h0C, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "div_m7_2");
    run_div(5'h0E, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "rem_m7_2");
    run_div(5'h0D, 32'd5,         32'd0,         32'hFFFF_FFFF, "divu_by0");
    run_div(5'h0C, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
    run_div(5'h0F, 32'd1000,      32'd7,         32'd6,         "remu_1000_7");
    run_div(5'h0C, 32'd7,         32'd0,         32'hFFFF_FFFF, "div_by0_s");
    run_div(5'h0E, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, "rem_by0_s");

    // Interrupt round trip on a normal result
    clear_ex();
    EX_ALUOp = 5'h00; EX_RD1 = 32'h55; EX_rd = 5'd9; EX_RegWrite = 1'b1;
    expect_at(cyc + 1, K_ALU, "int_pre", 32'h55);
    step();
    clear_ex();
    EX_NPCOp = 3'b010; EX_immout = 32'h8; INT_detected = 1'b1;
    expect_at(cyc,     K_FLUSH, "int_flush_supp", 32'd0);
    expect_at(cyc + 1, K_ALU,   "int_entry_alu",  32'd0);
    expect_at(cyc + 1, K_RD,    "int_entry_rd",   32'd0);
    step();
    clear_ex();
    INT_detected = 1'b0; INT_restore = 1'b1;
    expect_at(cyc + 1, K_ALU, "int_restore_alu", 32'h55);
    expect_at(cyc + 1, K_RD,  "int_restore_rd",  32'd9);
    step();
    INT_restore = 1'b0;
    step();

    // Divide interrupted at iteration 10: two frozen edges delay the result
    c = cyc;
    clear_ex();
    EX_ALUOp = 5'h0D; EX_RD1 = 32'd1000; EX_RD2 = 32'd7; EX_rd = 5'd4; EX_RegWrite = 1'b1;
    expect_at(c,      K_STALL, "idiv_stall0",   32'd1);
    expect_at(c + 34, K_STALL, "idiv_stall_hi", 32'd1);
    expect_at(c + 35, K_STALL, "idiv_stall_lo", 32'd0);
    expect_at(c + 35, K_ALU,   "idiv_bubble",   32'd0);
    expect_at(c + 36, K_ALU,   "idiv_result",   32'd142);
    step();
    clear_ex();
    repeat (9) step();
    INT_detected = 1'b1;
    step();
    INT_detected = 1'b0; INT_restore = 1'b1;
    step();
    INT_restore = 1'b0;
    repeat (24) step();

    // Reset mid-divide aborts with no result
    c = cyc;
    clear_ex();
    EX_ALUOp = 5'h0C; EX_RD1 = 32'd100; EX_RD2 = 32'd7; EX_rd = 5'd2; EX_RegWrite = 1'b1;
    step();
    clear_ex();
    repeat (4) step();
    reset = 1'b1;
    expect_at(c + 5, K_STALL, "rst_mid_stall", 32'd0);
    expect_at(c + 5, K_ALU,   "rst_mid_alu",   32'd0);
    step();
    reset = 1'b0;
    expect_at(c + 40, K_ALU,   "rst_mid_nores",   32'd0);
    expect_at(c + 40, K_RW,    "rst_mid_norw",    32'd0);
    expect_at(c + 40, K_STALL, "rst_mid_stall_l", 32'd0);
    repeat (37) step();

    if (sb.size() != 0) begin
      $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
      n_fail += sb.size();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage pipelined core. It sits between the ID/EX pipeline register and the data-memory stage, and consumes the EX_* bundle that ID/EX produces. It forwards operands from MEM/WB, evaluates the ALU, resolves branches and jumps, runs an iterative 32-cycle divider with pipeline stall, and drives the registered EX/MEM bundle (MEM_*). The EX/MEM register is saved on interrupt entry and restored on interrupt return.

## Interface
- DIV_CYCLES, 32: number of divider iterations; fixed, not tunable.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high; clears every register in the block.
- INT_detected / INT_restore  in  1  interrupt entry / return strobes.
- EX_PC, EX_RD1, EX_RD2, EX_immout  in  32  ID/EX data fields.
- EX_rs1, EX_rs2, EX_rd  in  5  ID/EX register indices.
- EX_dm_ctrl  in  3; EX_ALUOp  in  5; EX_WDSel  in  2; EX_NPCOp  in  3: ID/EX control fields.
- EX_RegWrite, EX_mem_w, EX_mem_read, EX_ALUSrc  in  1  ID/EX control bits.
- MEM_fwd_RegWrite  in  1; MEM_fwd_rd  in  5; MEM_fwd_data  in  32: MEM-stage forwarding source.
- WB_RegWrite  in  1; WB_rd  in  5; WB_WD  in  32: WB-stage forwarding source.
- EX_stall  out  1  to hazard unit: hold PC and IF/ID, flush ID/EX.
- EX_Flush_branch  out  1; EX_branch_target  out  32: redirect to PC/IF.
- MEM_PC, MEM_aluout, MEM_wdata  out  32  registered.
- MEM_rd  out  5; MEM_dm_ctrl  out  3; MEM_WDSel  out  2: registered.
- MEM_RegWrite, MEM_mem_w, MEM_mem_read  out  1  registered.

## Operation
- **Forwarding, A and B independently.** MEM wins over WB. A source matches when its RegWrite=1, its rd≠0 and its rd equals rs. With no match, use RD1/RD2.
- **Operand B selection.** ALU operand B = immout if ALUSrc=1, else forwarded B. MEM_wdata = forwarded B.
- **ALUOp encoding (hex).**
  - 00 ADD, 01 SUB, 02 SLL, 03 SLT, 04 SLTU, 05 XOR, 06 SRL, 07 SRA, 08 OR, 09 AND.
  - 0A LUI (passes B). 0B AUIPC (PC+B). Shift amount = B[4:0].
  - 0C DIV, 0D DIVU, 0E REM, 0F REMU.
  - 10–15: BEQ, BNE, BLT, BGE, BLTU, BGEU, compared on A vs forwarded B.
  - Any other code produces 0.
- **NPCOp.**
  - 000: sequential.
  - 001: conditional branch; taken iff the compare is true; target PC+imm.
  - 010: JAL; target PC+imm.
  - 100: JALR; target (A+imm)&~1.
  - Others are treated as 000.
- **EX_Flush_branch** is combinational: (taken or jump) & !INT_detected & !busy.
- **MEM_aluout** = PC+4 when WDSel=2'b10, else the ALU result.
- **Divider, restoring radix-2, states IDLE → RUN → DONE → IDLE.**
  - Accept: in IDLE with ALUOp in 0C–0F. Latch the magnitudes of A and B, the sign flags, op, rd, PC, RegWrite and WDSel. Go to RUN; counter = 0.
  - RUN: one quotient bit per edge. Go to DONE when the counter reaches 31.
  - DONE: apply signs. Load EX/MEM with the result (quotient for 0C/0D, remainder for 0E/0F). Go to IDLE.
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend.
  - Signed overflow (0x80000000 / -1): quotient = 0x80000000, remainder = 0.
- **EX_stall** = (IDLE & div op in EX) | RUN. It is low in DONE.
- **Bubble.** While in RUN, EX/MEM loads a bubble (all zeros) each edge. EX inputs are ignored (the hazard unit is flushing ID/EX).
- **Interrupt entry (INT_detected=1).**
  - backup ← EX/MEM contents; EX/MEM ← zeros.
  - The divider freezes (state and counter hold).
  - EX_Flush_branch is suppressed.
- **Interrupt return (INT_restore=1).** EX/MEM ← backup; the divider resumes.
- **Priority on simultaneous events:** reset > INT_detected > INT_restore > divider > normal load.

## Timing
- **Reset values.** All MEM_* = 0. Divider in IDLE, counter = 0, backup = 0. EX_stall = 0 and EX_Flush_branch = 0 while the EX inputs are zero.
- **Non-divide latency.** A non-divide instruction in EX at edge t appears on MEM_* after edge t.
- **Divide latency.**
  - Accept at edge t0. Iterations occupy edges t1..t32. Result is on MEM_* after edge t33.
  - EX_stall is high from the cycle before t0 through the cycle before t32, i.e. 33 stall cycles.
  - The instruction held in ID enters EX at edge t33, so the divide result forwards from MEM normally.
- **Reset mid-divide** aborts it with no result written.
- **Branch redirect** is combinational in the same cycle the branch is in EX. The hazard unit flushes IF/ID and ID/EX on the following edge.

## Test plan
- **Forwarding priority.** ADD, rs1=5; MEM_fwd rd=5 data=7; WB rd=5 data=9; RD1=1; B=3 → MEM_aluout=10. Repeat with rd=0 on both sources → 4.
- **BLT, signed compare.** ALUOp=12, NPCOp=001, A=0xFFFFFFFF, B=1, PC=0x100, imm=0x20 → EX_Flush_branch=1, target=0x120.
- **BLTU, unsigned compare.** Same operands with ALUOp=14 → EX_Flush_branch=0.
- **Divides.**
  - DIV −7/2 → MEM_aluout=0xFFFFFFFD after exactly 33 edges; EX_stall high for 33 cycles.
  - REM −7/2 → 0xFFFFFFFF.
  - DIVU 5/0 → 0xFFFFFFFF.
  - DIV 0x80000000/−1 → 0x80000000.
- **JALR.** A=0x203, imm=0, WDSel=10, PC=0x40 → target=0x202, MEM_aluout=0x44.
- **Interrupt round trip.** Pulse INT_detected with MEM_aluout=0x55 → MEM_* = 0 the next cycle. Pulse INT_restore → 0x55. A divide interrupted at iteration 10 resumes and still returns the correct quotient.
